controle_contagem_comparador: RTL and testbench
===============================================

CONTROLE_CONTAGEM_COMPARADOR -- requirements
Module: controle_contagem_comparador

Interface
REQ-001 Parameter SHALL be MAX_PASSOS, default 16: number of count increments allowed in one run before timeout.
REQ-002 Port clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  SHALL be asynchronous and active-high.
REQ-004 Port iniciar  input  1  SHALL be the start request, sampled only in INICIAL, FIM and ERRO.
REQ-005 Port conta  input  1  SHALL be the count enable, one increment per edge while high in CONTANDO.
REQ-006 Port valor_alvo  input  4  SHALL be the target value, captured on start.
REQ-007 Ports igual_cmp, maior_cmp, menor_cmp  input  1 each  SHALL be the A=B, A>B and A<B results returned by the downstream 4-bit cascadable comparator.
REQ-008 Port contagem  output  4  SHALL be the registered count, driven to comparator A3..A0.
REQ-009 Port alvo  output  4  SHALL be the registered target, driven to comparator B3..B0.
REQ-010 Ports cascata_maior, cascata_menor, cascata_igual  output  1 each  SHALL be constant 0, 0, 1 (single-stage cascade inputs).
REQ-011 Port contando  output  1  SHALL be high in CONTANDO.
REQ-012 Port fim  output  1  SHALL be high for exactly one cycle in FIM.
REQ-013 Port erro  output  1  SHALL be high in ERRO.
REQ-014 Port db_estado  output  2  SHALL expose the state encoding: INICIAL=00, CONTANDO=01, FIM=10, ERRO=11.

Function
REQ-015 The block SHALL be a Moore FSM with states INICIAL, CONTANDO, FIM, ERRO; contando/fim/erro/db_estado decode state only.
REQ-016 In INICIAL, FIM or ERRO with iniciar=1, next edge SHALL load contagem=0, alvo=valor_alvo, passos=0, state CONTANDO.
REQ-017 In INICIAL with iniciar=0, state and all registers SHALL hold.
REQ-018 In CONTANDO, comparator feedback SHALL be evaluated combinationally in the same cycle, with priority: invalid > igual > maior > timeout > conta.
REQ-019 Invalid feedback (not exactly one of igual_cmp/maior_cmp/menor_cmp high) in CONTANDO SHALL move to ERRO next edge, contagem held.
REQ-020 igual_cmp=1 in CONTANDO SHALL move to FIM next edge with no increment, even if conta=1.
REQ-021 maior_cmp=1 in CONTANDO (count overtook target) SHALL move to ERRO next edge.
REQ-022 passos==MAX_PASSOS with igual_cmp=0 in CONTANDO SHALL move to ERRO next edge.
REQ-023 Otherwise conta=1 SHALL increment contagem and passos by 1; conta=0 SHALL hold both.
REQ-024 contagem SHALL wrap modulo 16 (15+1=0); passos SHALL be wide enough to hold MAX_PASSOS without wrap.
REQ-025 iniciar SHALL be ignored in CONTANDO.
REQ-026 FIM SHALL last one cycle then return to INICIAL unless iniciar=1 (then CONTANDO); contagem and alvo hold final values.
REQ-027 ERRO SHALL persist until iniciar=1 or reset.
REQ-028 alvo SHALL change only on a start; valor_alvo changes at other times SHALL have no effect.

Reset
REQ-029 reset=1 SHALL immediately, without waiting for clock, force state INICIAL, contagem=0, alvo=0, passos=0; thus contando=0, fim=0, erro=0, db_estado=00.
REQ-030 Reset asserted mid-run (any state) SHALL abort the run; after release the block SHALL wait in INICIAL for iniciar.
REQ-031 Cascade outputs SHALL remain 0,0,1 during and after reset.

Verification
REQ-032 Bench with real comparator: valor_alvo=5, iniciar pulse, conta held 1 -> contagem 0..5 on successive edges, fim high one cycle on the edge after contagem=5, then db_estado=00, contagem=5.
REQ-033 valor_alvo=0, iniciar -> first CONTANDO cycle sees igual, FIM on next edge, contagem stays 0, no increment.
REQ-034 valor_alvo=9, conta toggling 1/0 -> contagem advances only on conta=1 edges, fim after contagem=9.
REQ-035 Forced feedback igual_cmp=maior_cmp=1 in CONTANDO -> ERRO next edge, erro=1 held; iniciar with valor_alvo=3 -> CONTANDO, contagem=0, alvo=3.
REQ-036 MAX_PASSOS=4, stubbed menor_cmp=1 constantly, conta=1 -> contagem reaches 4 then ERRO, no further increments.
REQ-037 valor_alvo=12, reset asserted between edges at contagem=7 -> outputs at reset values immediately, stay in INICIAL after release until iniciar.

Source files
------------

// File: rtl/controle_contagem_comparador.sv
// Count-and-compare controller: counts up from 0 toward a captured target and
// relies on an external 4-bit comparator to decide when the target is reached.
module controle_contagem_comparador #(
  parameter int MAX_PASSOS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       conta,
  input  logic [3:0] valor_alvo,
  input  logic       igual_cmp,
  input  logic       maior_cmp,
  input  logic       menor_cmp,
  output logic [3:0] contagem,
  output logic [3:0] alvo,
  output logic       cascata_maior,
  output logic       cascata_menor,
  output logic       cascata_igual,
  output logic       contando,
  output logic       fim,
  output logic       erro,
  output logic [1:0] db_estado
);

  localparam int PW = $clog2(MAX_PASSOS + 1);

  typedef enum logic [1:0] {
    INICIAL  = 2'b00,
    CONTANDO = 2'b01,
    FIM      = 2'b10,
    ERRO     = 2'b11
  } estado_t;

  estado_t       estado;
  logic [PW-1:0] passos;
  logic [1:0]    n_altos;
  logic          fb_invalido;
  logic          esgotado;

  // Comparator feedback is trusted only when exactly one relation is asserted.
  assign n_altos     = {1'b0, igual_cmp} + {1'b0, maior_cmp} + {1'b0, menor_cmp};
  assign fb_invalido = (n_altos != 2'd1);
  assign esgotado    = (passos == PW'(MAX_PASSOS));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= INICIAL;
      contagem <= 4'd0;
      alvo     <= 4'd0;
      passos   <= '0;
    end else begin
      case (estado)
        INICIAL, FIM, ERRO: begin
          if (iniciar) begin
            estado   <= CONTANDO;
            contagem <= 4'd0;
            alvo     <= valor_alvo;
            passos   <= '0;
          end else if (estado == FIM) begin
            estado <= INICIAL;
          end
        end
        CONTANDO: begin
          // Priority: invalid feedback, equal, overtaken, step budget, count.
          if (fb_invalido) begin
            estado <= ERRO;
          end else if (igual_cmp) begin
            estado <= FIM;
          end else if (maior_cmp) begin
            estado <= ERRO;
          end else if (esgotado) begin
            estado <= ERRO;
          end else if (conta) begin
            contagem <= contagem + 4'd1;
            passos   <= passos + PW'(1);
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

  assign contando      = (estado == CONTANDO);
  assign fim           = (estado == FIM);
  assign erro          = (estado == ERRO);
  assign db_estado     = estado;

  // Single-stage comparator: cascade inputs tie to "equal so far".
  assign cascata_maior = 1'b0;
  assign cascata_menor = 1'b0;
  assign cascata_igual = 1'b1;

endmodule

// File: tb/tb_controle_contagem_comparador.sv
// Bench for controle_contagem_comparador: two instances (budget 16 and 4) share
// stimulus; a comparator stub feeds them, and a reference model predicts outputs.
module tb_controle_contagem_comparador;

  localparam int ST_I = 0, ST_C = 1, ST_F = 2, ST_E = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       conta = 1'b0;
  logic [3:0] valor_alvo = 4'd0;

  logic [1:0]      frc = 2'b00;
  logic [1:0][2:0] fpat = '0;  // forced {igual, maior, menor}

  logic [1:0][3:0] cnt_w, alvo_w;
  logic [1:0][1:0] db_w;
  logic [1:0]      ig_w, ma_w, me_w;
  logic [1:0]      cm_w, cme_w, ci_w, contando_w, fim_w, erro_w;

  int m_st[2], m_cnt[2], m_alvo[2], m_pas[2];
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // Comparator stub: real magnitude compare unless a pattern is forced.
  for (genvar g = 0; g < 2; g++) begin : g_cmp
    assign ig_w[g] = frc[g] ? fpat[g][2] : (cnt_w[g] == alvo_w[g]);
    assign ma_w[g] = frc[g] ? fpat[g][1] : (cnt_w[g] >  alvo_w[g]);
    assign me_w[g] = frc[g] ? fpat[g][0] : (cnt_w[g] <  alvo_w[g]);
  end

  controle_contagem_comparador #(.MAX_PASSOS(16)) dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .conta(conta),
    .valor_alvo(valor_alvo), .igual_cmp(ig_w[0]), .maior_cmp(ma_w[0]),
    .menor_cmp(me_w[0]), .contagem(cnt_w[0]), .alvo(alvo_w[0]),
    .cascata_maior(cm_w[0]), .cascata_menor(cme_w[0]), .cascata_igual(ci_w[0]),
    .contando(contando_w[0]), .fim(fim_w[0]), .erro(erro_w[0]),
    .db_estado(db_w[0])
  );

  controle_contagem_comparador #(.MAX_PASSOS(4)) dut1 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .conta(conta),
    .valor_alvo(valor_alvo), .igual_cmp(ig_w[1]), .maior_cmp(ma_w[1]),
    .menor_cmp(me_w[1]), .contagem(cnt_w[1]), .alvo(alvo_w[1]),
    .cascata_maior(cm_w[1]), .cascata_menor(cme_w[1]), .cascata_igual(ci_w[1]),
    .contando(contando_w[1]), .fim(fim_w[1]), .erro(erro_w[1]),
    .db_estado(db_w[1])
  );

  task automatic chk(string tag, int d, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = ST_I; m_cnt[d] = 0; m_alvo[d] = 0; m_pas[d] = 0;
    end
  endfunction

  function automatic void model_start(int d);
    m_st[d] = ST_C; m_cnt[d] = 0; m_alvo[d] = int'(valor_alvo); m_pas[d] = 0;
  endfunction

  // One rising edge of behaviour, from the rules stated for the block.
  function automatic void model_step(int d);
    int budget = (d == 0) ? 16 : 4;
    int eq, gt, lt;
    if (frc[d]) begin
      eq = int'(fpat[d][2]); gt = int'(fpat[d][1]); lt = int'(fpat[d][0]);
    end else begin
      eq = (m_cnt[d] == m_alvo[d]) ? 1 : 0;
      gt = (m_cnt[d] >  m_alvo[d]) ? 1 : 0;
      lt = (m_cnt[d] <  m_alvo[d]) ? 1 : 0;
    end
    if (m_st[d] == ST_C) begin
      if (eq + gt + lt != 1)          m_st[d] = ST_E;
      else if (eq == 1)               m_st[d] = ST_F;
      else if (gt == 1)               m_st[d] = ST_E;
      else if (m_pas[d] == budget)    m_st[d] = ST_E;
      else if (conta) begin
        m_cnt[d] = (m_cnt[d] + 1) % 16;
        m_pas[d] = m_pas[d] + 1;
      end
    end else if (iniciar) begin
      model_start(d);
    end else if (m_st[d] == ST_F) begin
      m_st[d] = ST_I;
    end
  endfunction

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk("contagem",  d, 8'(cnt_w[d]),      8'(m_cnt[d]));
      chk("alvo",      d, 8'(alvo_w[d]),     8'(m_alvo[d]));
      chk("db_estado", d, 8'(db_w[d]),       8'(m_st[d]));
      chk("contando",  d, 8'(contando_w[d]), 8'(m_st[d] == ST_C));
      chk("fim",       d, 8'(fim_w[d]),      8'(m_st[d] == ST_F));
      chk("erro",      d, 8'(erro_w[d]),     8'(m_st[d] == ST_E));
      chk("cascata",   d, 8'({cm_w[d], cme_w[d], ci_w[d]}), 8'd1);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step(0);
    model_step(1);
    @(negedge clock);
    check_all();
  endtask

  initial begin
    // Reset state, then idle in INICIAL.
    reset = 1'b1;
    @(negedge clock);
    model_reset();
    check_all();
    reset = 1'b0;
    valor_alvo = 4'd6;
    tick();

    // Target 5, conta held high: 0..5, then one FIM cycle, then INICIAL.
    valor_alvo = 4'd5; iniciar = 1'b1; conta = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("r32_cnt0", 0, 8'(cnt_w[0]), 8'd0);
    chk("r32_alvo", 0, 8'(alvo_w[0]), 8'd5);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("r32_cnt", 0, 8'(cnt_w[0]), 8'(i));
    end
    tick();
    chk("r32_fim", 0, 8'(fim_w[0]), 8'd1);
    chk("r32_fim_cnt", 0, 8'(cnt_w[0]), 8'd5);
    tick();
    chk("r32_db_after", 0, 8'(db_w[0]), 8'd0);
    chk("r32_cnt_after", 0, 8'(cnt_w[0]), 8'd5);

    // Target 0: equal on the first counting cycle, no increment.
    valor_alvo = 4'd0; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    chk("r33_fim", 0, 8'(fim_w[0]), 8'd1);
    chk("r33_cnt", 0, 8'(cnt_w[0]), 8'd0);
    tick();

    // Target 9 with conta toggling.
    valor_alvo = 4'd9; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        conta = i[0];
        tick();
        if (fim_w[0]) seen = 1'b1;
      end
      chk("r34_fim_seen", 0, 8'(seen), 8'd1);
      chk("r34_cnt", 0, 8'(cnt_w[0]), 8'd9);
    end
    conta = 1'b1;
    tick();

    // Invalid feedback (igual and maior together) leads to a sticky ERRO.
    valor_alvo = 4'd7; iniciar = 1'b1;
    tick();
    iniciar = 1'b0; frc[0] = 1'b1; fpat[0] = 3'b110;
    tick();
    chk("r35_erro", 0, 8'(erro_w[0]), 8'd1);
    chk("r35_cnt", 0, 8'(cnt_w[0]), 8'd0);
    tick();
    tick();
    chk("r35_erro_held", 0, 8'(erro_w[0]), 8'd1);
    frc[0] = 1'b0; valor_alvo = 4'd3; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("r35_restart_db", 0, 8'(db_w[0]), 8'd1);
    chk("r35_restart_alvo", 0, 8'(alvo_w[0]), 8'd3);
    chk("r35_restart_cnt", 0, 8'(cnt_w[0]), 8'd0);

    // Step budget of 4 with the comparator stuck at "less than".
    frc[1] = 1'b1; fpat[1] = 3'b001; valor_alvo = 4'd10; iniciar = 1'b1; conta = 1'b1;
    tick();
    iniciar = 1'b0;
    repeat (5) tick();
    chk("r36_erro", 1, 8'(erro_w[1]), 8'd1);
    chk("r36_cnt", 1, 8'(cnt_w[1]), 8'd4);
    repeat (3) tick();
    chk("r36_cnt_held", 1, 8'(cnt_w[1]), 8'd4);
    frc[1] = 1'b0;

    // Asynchronous reset in the middle of a run at contagem=7.
    valor_alvo = 4'd12; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    repeat (7) tick();
    chk("r37_cnt7", 0, 8'(cnt_w[0]), 8'd7);
    reset = 1'b1;
    #1;
    model_reset();
    chk("r37_rst_cnt", 0, 8'(cnt_w[0]), 8'd0);
    chk("r37_rst_alvo", 0, 8'(alvo_w[0]), 8'd0);
    chk("r37_rst_db", 0, 8'(db_w[0]), 8'd0);
    check_all();
    #1;
    reset = 1'b0;
    repeat (3) tick();
    chk("r37_wait_db", 0, 8'(db_w[0]), 8'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      conta      = ($urandom_range(0, 3) != 0);
      iniciar    = ($urandom_range(0, 7) == 0);
      valor_alvo = 4'($urandom_range(0, 15));
      for (int d = 0; d < 2; d++) begin
        frc[d]  = ($urandom_range(0, 19) == 0);
        fpat[d] = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        reset = 1'b0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
